// File: rtl/formula_pkg.sv
// Shared types and defaults for the formula pipeline and its result buffer.
package formula_pkg;

  localparam int FORMULA_W       = 32;
  localparam int FORMULA_LATENCY = 14;

  typedef logic [FORMULA_W-1:0] formula_res_t;

endpackage

// File: rtl/result_fifo_mem.sv
// Register-array storage for the result FIFO: one write port, one asynchronous read port.
module result_fifo_mem
  import formula_pkg::*;
#(
  parameter int WIDTH = FORMULA_W,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the data array has no reset; occupancy in the top module decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/formula_result_buffer.sv
// Credit-controlled result FIFO behind the fixed-latency formula pipeline.
// Define FORMULA_RESULT_BUFFER_BYPASS_EN for a zero-latency path through an empty buffer.
module formula_result_buffer
  import formula_pkg::*;
#(
  parameter int WIDTH   = FORMULA_W,
  parameter int DEPTH   = 16,
  parameter int LATENCY = FORMULA_LATENCY
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arg_vld,
  output logic                       arg_rdy,
  input  logic                       res_vld,
  input  logic [WIDTH-1:0]           res,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW:0]   DEPTH_SUM = (LW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LATENCY < 1) begin : g_cfg_check
    $error("formula_result_buffer: DEPTH must be a power of two >= 2 and LATENCY >= 1");
  end

  logic [LW-1:0]    in_flight;
  logic [LW-1:0]    count;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] rd_data;

  logic fifo_nonempty;
  logic bypass_vld;
  logic fifo_pop;
  logic issue;
  logic ret_ok;
  logic push;

  assign fifo_nonempty = (count != '0);

  // Credits depend on registers only, so upstream never sees a path from its own arg_vld.
  assign arg_rdy = rst & (({1'b0, in_flight} + {1'b0, count}) < DEPTH_SUM);

`ifdef FORMULA_RESULT_BUFFER_BYPASS_EN
  assign bypass_vld = ~fifo_nonempty & res_vld & (in_flight != '0);
`else
  assign bypass_vld = 1'b0;
`endif

  assign out_vld  = fifo_nonempty | bypass_vld;
  assign out_data = fifo_nonempty ? rd_data : (bypass_vld ? res : '0);
  assign level    = count;

  assign fifo_pop = fifo_nonempty & out_rdy;
  assign issue    = arg_vld & arg_rdy;
  // A return is accepted only if it was credited and has somewhere to go; a pop frees a full slot.
  assign ret_ok   = res_vld & (in_flight != '0) & ((count != FULL_LVL) | fifo_pop);
  assign push     = ret_ok & ~(bypass_vld & out_rdy);

  result_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (res),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // NOTE: state registers use non-blocking assignments so every read in this block sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_flight <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      err       <= 1'b0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + PTR_ONE;
      if (fifo_pop) rd_ptr <= rd_ptr + PTR_ONE;

      case ({issue, ret_ok})
        2'b10:   in_flight <= in_flight + LVL_ONE;
        2'b01:   in_flight <= in_flight - LVL_ONE;
        default: ;
      endcase

      case ({push, fifo_pop})
        2'b10:   count <= count + LVL_ONE;
        2'b01:   count <= count - LVL_ONE;
        default: ;
      endcase

      if ((arg_vld & ~arg_rdy) | (res_vld & ~ret_ok)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_formula_result_buffer.sv
// Self-checking bench for formula_result_buffer: directed table, corner sequences, randomized model check.
module tb_formula_result_buffer;
  import formula_pkg::*;

  localparam int DEPTH   = 16;
  localparam int LATENCY = FORMULA_LATENCY;
  localparam int LW      = $clog2(DEPTH + 1);
`ifdef FORMULA_RESULT_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk     = 1'b0;
  logic          rst     = 1'b0;
  logic          arg_vld = 1'b0;
  logic          res_vld = 1'b0;
  logic          out_rdy = 1'b0;
  formula_res_t  res     = '0;
  logic          arg_rdy;
  logic          out_vld;
  formula_res_t  out_data;
  logic [LW-1:0] level;
  logic          err;

  always #5 clk = ~clk;

  formula_result_buffer #(
    .WIDTH   (FORMULA_W),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .arg_vld  (arg_vld),
    .arg_rdy  (arg_rdy),
    .res_vld  (res_vld),
    .res      (res),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .level    (level),
    .err      (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight count, queue of buffered results, sticky error, and the feeding pipeline.
  typedef struct {
    int           due;
    formula_res_t d;
  } pend_t;

  int           mf;
  bit           me;
  int           cyc;
  formula_res_t mq[$];
  pend_t        pipe[$];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; arg_vld = 1'b0; res_vld = 1'b0; out_rdy = 1'b0; res = '0;
    #1;
    check("rst_arg_rdy", arg_rdy, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_out_data", out_data, 0);
    check("rst_level", level, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b1;
    mq.delete(); pipe.delete();
    mf = 0; me = 1'b0; cyc = 0;
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic cycle(input bit want_arg, input formula_res_t aval, input bit ordy,
                       input bit force_arg, output bit d_iss, output bit d_pop,
                       output formula_res_t d_data);
    bit e_rdy, e_vld, byp, iss, ret, pop;
    formula_res_t e_data;
    pend_t p;
    @(negedge clk);
    e_rdy   = (mf + mq.size()) < DEPTH;
    arg_vld = force_arg | (want_arg & e_rdy);
    if (pipe.size() != 0 && pipe[0].due == cyc) begin
      res_vld = 1'b1; res = pipe[0].d; pipe.delete(0);
    end else begin
      res_vld = 1'b0; res = $urandom;
    end
    out_rdy = ordy;
    #1;
    byp    = BYP && mq.size() == 0 && res_vld && mf > 0;
    e_vld  = mq.size() != 0 || byp;
    e_data = (mq.size() != 0) ? mq[0] : (byp ? res : '0);
    check("arg_rdy", arg_rdy, e_rdy);
    check("out_vld", out_vld, e_vld);
    if (e_vld) check("out_data", out_data, e_data);
    check("level", level, mq.size());
    check("err", err, me);
    d_iss  = arg_vld & arg_rdy;
    d_pop  = out_vld & ordy;
    d_data = out_data;
    iss = arg_vld && e_rdy;
    if (arg_vld && !e_rdy) me = 1'b1;
    pop = e_vld && ordy;
    ret = res_vld && mf > 0 && (mq.size() < DEPTH || pop);
    if (res_vld && !ret) me = 1'b1;
    if (pop && mq.size() != 0) mq.delete(0);
    if (ret && !(byp && ordy)) mq.push_back(res);
    mf = mf + int'(iss) - int'(ret);
    if (iss) begin
      p.due = cyc + LATENCY; p.d = aval;
      pipe.push_back(p);
    end
    cyc++;
  endtask

  typedef struct {
    bit           a;
    bit           rv;
    formula_res_t r;
    bit           ordy;
    bit           e_rdy;
    bit           e_vld;
    formula_res_t e_data;
    int           e_lvl;
    bit           e_err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    bit           iss, pop;
    formula_res_t d, got_v;
    int           n, pop_cyc, nxt;
    formula_res_t got[$];

    tbl[0] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0, 0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'h11, 1'b0, 1'b1, BYP,  BYP ? 32'h11 : 32'h0, 0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h11, 1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h11, 1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 32'h22, 1'b1, 1'b1, BYP,  BYP ? 32'h22 : 32'h0, 0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, !BYP, BYP ? 32'h0 : 32'h22, BYP ? 0 : 1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 32'h33, 1'b0, 1'b1, 1'b0, 32'h0, 0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0, 0, 1'b1};

    // Directed table, including a result returned with nothing in flight.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      arg_vld = tbl[i].a; res_vld = tbl[i].rv; res = tbl[i].r; out_rdy = tbl[i].ordy;
      #1;
      check("tbl_arg_rdy", arg_rdy, tbl[i].e_rdy);
      check("tbl_out_vld", out_vld, tbl[i].e_vld);
      if (tbl[i].e_vld) check("tbl_out_data", out_data, tbl[i].e_data);
      check("tbl_level", level, tbl[i].e_lvl);
      check("tbl_err", err, tbl[i].e_err);
    end
    @(negedge clk);
    arg_vld = 1'b0; res_vld = 1'b0; out_rdy = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("err_sticky_res", err, 1);
    check("err_level_res", level, 0);

    // Single pass through the pipeline latency.
    do_reset();
    cycle(1'b1, 32'h7, 1'b1, 1'b0, iss, pop, d);
    check("sp_issue", iss, 1);
    pop_cyc = -1; got_v = '0;
    for (int k = 1; k < 40 && pop_cyc < 0; k++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, iss, pop, d);
      if (pop) begin pop_cyc = k; got_v = d; end
    end
    check("sp_latency", pop_cyc, BYP ? LATENCY : LATENCY + 1);
    check("sp_data", got_v, 32'h7);
    check("sp_in_flight", dut.in_flight, 0);
    check("sp_err", err, 0);

    // Credit exhaustion with a stalled consumer.
    do_reset();
    n = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 32'(100 + k), 1'b0, 1'b0, iss, pop, d);
      n += int'(iss);
    end
    check("credit_issues", n, 16);
    repeat (20) cycle(1'b0, '0, 1'b0, 1'b0, iss, pop, d);
    check("credit_level", level, 16);
    check("credit_arg_rdy", arg_rdy, 0);
    cycle(1'b0, '0, 1'b0, 1'b1, iss, pop, d);
    cycle(1'b0, '0, 1'b0, 1'b0, iss, pop, d);
    check("err_sticky_arg", err, 1);
    check("err_level_arg", level, 16);
    cycle(1'b0, '0, 1'b1, 1'b0, iss, pop, d);
    check("credit_first_pop", d, 100);
    cycle(1'b0, '0, 1'b0, 1'b0, iss, pop, d);
    check("credit_restored", arg_rdy, 1);
    // Refill to 16 with one new result, then drain and confirm it landed last.
    cycle(1'b1, 32'hF00D, 1'b0, 1'b0, iss, pop, d);
    repeat (LATENCY + 1) cycle(1'b0, '0, 1'b0, 1'b0, iss, pop, d);
    check("refill_level", level, 16);
    got.delete();
    for (int k = 0; k < 40 && got.size() < 16; k++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, iss, pop, d);
      if (pop) got.push_back(d);
    end
    check("drain_count", got.size(), 16);
    if (got.size() == 16) check("full_new_value", got[15], 32'hF00D);

    // Streaming 0..99 with a 50% consumer.
    do_reset();
    nxt = 0; got.delete();
    for (int k = 0; k < 3000 && got.size() < 100; k++) begin
      cycle(nxt < 100, formula_res_t'(nxt), 1'($urandom % 2), 1'b0, iss, pop, d);
      if (arg_vld) nxt++;
      if (pop) got.push_back(d);
    end
    check("stream_count", got.size(), 100);
    for (int i = 0; i < got.size() && i < 100; i++) check("stream_order", got[i], i);
    check("stream_err", err, 0);

    // Full-rate streaming keeps credits available.
    do_reset();
    n = 0;
    for (int k = 0; k < 60; k++) begin
      cycle(1'b1, $urandom, 1'b1, 1'b0, iss, pop, d);
      n += int'(iss);
    end
    check("steady_issues", n, 60);

    // Randomized traffic with a reset in the middle.
    do_reset();
    for (int k = 0; k < 500; k++) begin
      if (k == 250) do_reset();
      cycle(1'($urandom % 10 < 7), $urandom, 1'($urandom % 10 < 6), 1'b0, iss, pop, d);
    end

`ifdef FORMULA_RESULT_BUFFER_BYPASS_EN
    do_reset();
    cycle(1'b1, 32'hABCD, 1'b1, 1'b0, iss, pop, d);
    repeat (LATENCY - 1) cycle(1'b0, '0, 1'b1, 1'b0, iss, pop, d);
    cycle(1'b0, '0, 1'b1, 1'b0, iss, pop, d);
    check("byp_same_cycle", pop, 1);
    check("byp_data", d, 32'hABCD);
    cycle(1'b0, '0, 1'b1, 1'b0, iss, pop, d);
    check("byp_level", level, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/formula_result_buffer.md
# formula_result_buffer

Downstream companion to the pipelined formula block. The formula pipeline has fixed latency and cannot stall, so this block captures every result it emits, holds results in a FIFO, and offers them on a valid/ready output port. It also issues credits upstream so that no more arguments enter the pipeline than the FIFO can absorb, which makes overflow impossible in correct use.

## Interface
Parameters:
- WIDTH, 32: result data width.
- DEPTH, 16: FIFO entries, power of two, ≥ 2.
- LATENCY, 14: fixed arg-to-result latency of the feeding pipeline. Used only by the checker.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- arg_vld  in  1  argument issued into the formula pipeline this cycle.
- arg_rdy  out  1  credit available; upstream may assert arg_vld only when high.
- res_vld  in  1  result valid from the formula pipeline.
- res  in  WIDTH  result data.
- out_vld  out  1  output data valid.
- out_rdy  in  1  downstream accepts.
- out_data  out  WIDTH  output data.
- level  out  $clog2(DEPTH+1)  current FIFO occupancy.
- err  out  1  sticky protocol error.

## Operation
- Counters: `in_flight` counts args issued but not yet returned (0..DEPTH). `count` is FIFO occupancy (0..DEPTH).
- arg_rdy = (in_flight + count) < DEPTH. It is computed from registers only, with no path from arg_vld. It is forced to 0 while rst is low.
- Issue event: arg_vld & arg_rdy increments in_flight.
- Return event: res_vld decrements in_flight and pushes res.
- Simultaneous issue and return: in_flight is unchanged.
- arg_vld while arg_rdy=0: the argument is not counted and err is set.
- res_vld with in_flight=0, or res_vld with count=DEPTH and no pop in the same cycle: res is dropped, err is set, counters are unchanged.
- Pop: out_vld & out_rdy advances rd_ptr and decrements count.
- Push and pop in the same cycle: count is unchanged. This is legal at count=DEPTH, because the pop frees the slot.
- Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are determined from count, not from pointer equality.
- err clears only on reset.
- Data path has no arithmetic. res passes through bit-exact.

## Timing
- Reset values: arg_rdy=0 while rst is low, then 1 from the first cycle after release. out_vld=0, out_data=0, level=0, err=0, all pointers and counters 0.
- Without bypass: a result pushed in cycle N is visible on out_vld/out_data in cycle N+1.
- out_data is held stable while out_vld=1 & out_rdy=0.
- level updates one cycle after the push or pop that changes it.
- Steady state: with out_rdy held at 1, one result is accepted and delivered per cycle, and arg_rdy stays high indefinitely.
- Reset asserted mid-operation: FIFO contents and counters are discarded immediately. The feeding pipeline is reset by the same signal, so in-flight results never return.

## Configuration
- FORMULA_RESULT_BUFFER_BYPASS_EN defined:
  - When count=0 and res_vld=1, res is driven combinationally on out_data with out_vld=1 in the same cycle.
  - If out_rdy=1 in that cycle, the result is not written to the FIFO and count stays 0.
  - Zero-cycle latency through an empty buffer.
- Not defined: the registered path only, with 1-cycle minimum latency and no combinational path from res to out_data.

## Structure
- Package formula_pkg:
  - FORMULA_W = 32 and FORMULA_LATENCY = 14 constants.
  - Typedef formula_res_t = logic [FORMULA_W-1:0].
  - Parameter defaults reference these.
- Sub-module result_fifo_mem:
  - Dual-pointer register-array storage (write port, read port), no reset on the data array.
  - Credit logic, counters and err stay in the top module.

## Test plan
- Single pass:
  - Stimulus: reset, then one arg_vld; res_vld with res=32'h0000_0007 after 14 cycles; out_rdy=1.
  - Required: out_data=7 with out_vld one cycle later; in_flight returns to 0; err=0.
- Credit exhaustion:
  - Stimulus: out_rdy=0, arg_vld every cycle.
  - Required: arg_rdy drops after exactly 16 issues. After all 16 results return, level=16 and arg_rdy stays 0 until one pop.
- Streaming:
  - Stimulus: 100 back-to-back args with results 0..99; out_rdy random 50%.
  - Required: outputs appear in order 0..99, none lost or duplicated, err=0.
- Full push+pop:
  - Stimulus: count=16; res_vld and out_vld & out_rdy in the same cycle.
  - Required: count stays 16, the new value is stored, err=0.
- Protocol errors:
  - Stimulus: res_vld with in_flight=0 (first case); arg_vld while arg_rdy=0 (second case).
  - Required: err=1 in each case, stays 1 until rst low, and level is unchanged.
- Bypass (FORMULA_RESULT_BUFFER_BYPASS_EN):
  - Stimulus: empty FIFO, res=32'hABCD, out_rdy=1.
  - Required: out_vld=1 and out_data=32'hABCD in the same cycle; level stays 0.
